// File: rtl/decode_stage.sv
// decode_stage: RV instruction decoder with registered output and one-entry skid buffer
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       inst_type,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic             r_wen,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      typ;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            wen;
    logic            ill;
  } bundle_t;
  bundle_t dec, out_q, skid_q;
  logic skid_valid, accept, drain;
  logic [6:0] op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op    = instruction[6:0];
  assign imm_i = XLEN'($signed(instruction[31:20]));
  assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_b = XLEN'($signed({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}));
  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = instruction[11:7];
    dec.rs1 = instruction[19:15];
    dec.rs2 = instruction[24:20];
    case (op)
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: dec.typ = 3'd0;
      7'b0110111, 7'b0010111:                                     dec.typ = 3'd1;
      7'b0100011:                                                 dec.typ = 3'd2;
      7'b1101111:                                                 dec.typ = 3'd3;
      7'b0110011, 7'b0111011:                                     dec.typ = 3'd4;
      7'b1100011:                                                 dec.typ = 3'd5;
      default:                                                    dec.typ = 3'd7;
    endcase
    dec.ill = dec.typ == 3'd7;
    dec.imm = dec.typ == 3'd0 ? imm_i :
              dec.typ == 3'd1 ? imm_u :
              dec.typ == 3'd2 ? imm_s :
              dec.typ == 3'd3 ? imm_j :
              dec.typ == 3'd5 ? imm_b : '0;
    dec.wen = (dec.typ == 3'd0 || dec.typ == 3'd1 || dec.typ == 3'd3 || dec.typ == 3'd4) && dec.rd != 5'd0;
  end
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = !out_valid || out_ready;
  // skid only fills while the output stalls, so it is always older than any new input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      ill_cnt    <= '0;
    end else begin
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (drain) begin
        out_valid  <= skid_valid || accept;
        skid_valid <= 1'b0;
        if (skid_valid) out_q <= skid_q;
        else if (accept) out_q <= dec;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_q     <= dec;
      end
      if (!flush && accept && dec.ill && ill_cnt != '1) ill_cnt <= ill_cnt + 1'b1;
    end
  end
  assign out_pc    = out_q.pc;
  assign inst_type = out_q.typ;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign imm       = out_q.imm;
  assign r_wen     = out_q.wen;
  assign illegal   = out_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a queue-based model
module tb_decode_stage;
  localparam int XLEN = 64;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instruction = 0;
  logic [XLEN-1:0] in_pc = 0;
  logic in_ready, out_valid, r_wen, illegal;
  logic [XLEN-1:0] out_pc, imm;
  logic [2:0] inst_type;
  logic [4:0] rd, rs1, rs2;
  logic [CNT_W-1:0] ill_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic [XLEN-1:0] pc;
    int typ;
    int rd;
    int rs1;
    int rs2;
    logic [XLEN-1:0] imm;
    bit wen;
    bit ill;
  } exp_t;
  exp_t q[$];
  int cnt = 0;
  bit m_fire, m_acc;
  logic [6:0] ops [12] = '{7'h13, 7'h1b, 7'h03, 7'h67, 7'h73, 7'h37, 7'h17, 7'h23, 7'h6f, 7'h33, 7'h3b, 7'h63};
  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .inst_type(inst_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .r_wen(r_wen), .illegal(illegal), .ill_cnt(ill_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(logic [31:0] i, logic [XLEN-1:0] pc);
    exp_t e;
    logic [6:0] op = i[6:0];
    longint s = longint'($signed(i));
    longint v = 0;
    e.pc = pc;
    e.rd = int'(i[11:7]);
    e.rs1 = int'(i[19:15]);
    e.rs2 = int'(i[24:20]);
    if (op inside {7'h13, 7'h1b, 7'h03, 7'h67, 7'h73}) e.typ = 0;
    else if (op inside {7'h37, 7'h17}) e.typ = 1;
    else if (op == 7'h23) e.typ = 2;
    else if (op == 7'h6f) e.typ = 3;
    else if (op inside {7'h33, 7'h3b}) e.typ = 4;
    else if (op == 7'h63) e.typ = 5;
    else e.typ = 7;
    case (e.typ)
      0: v = s >>> 20;
      1: v = s & ~longint'(12'hfff);
      2: v = ((s >>> 25) << 5) | longint'(i[11:7]);
      3: v = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      5: v = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      default: v = 0;
    endcase
    e.imm = v;
    e.wen = (e.typ inside {0, 1, 3, 4}) && e.rd != 0;
    e.ill = e.typ == 7;
    return e;
  endfunction
  // occupancy-2 queue: in_ready means fewer than two bundles held
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cnt = 0;
    end else begin
      m_fire = q.size() > 0 && out_ready;
      m_acc = in_valid && q.size() < 2;
      if (flush) q.delete();
      else begin
        if (m_fire) void'(q.pop_front());
        if (m_acc) begin
          q.push_back(model(instruction, in_pc));
          if (q[$].ill && cnt < CNT_MAX) cnt++;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("ill_cnt", ill_cnt, cnt);
      if (q.size() > 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("inst_type", inst_type, q[0].typ);
        chk("rd", rd, q[0].rd);
        chk("rs1", rs1, q[0].rs1);
        chk("rs2", rs2, q[0].rs2);
        chk("imm", imm, q[0].imm);
        chk("r_wen", r_wen, q[0].wen);
        chk("illegal", illegal, q[0].ill);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(bit v, logic [31:0] ins, logic [XLEN-1:0] pc);
    in_valid = v;
    instruction = ins;
    in_pc = pc;
  endtask
  initial begin
    logic [31:0] r;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ill_cnt", ill_cnt, 0);
    chk("rst_imm", imm, 0);
    chk("rst_out_pc", out_pc, 0);
    @(negedge clk);
    rst = 1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1;
    drive(1, 32'h00500093, 64'h8000_0000);
    step();
    chk("addi_valid", out_valid, 1);
    chk("addi_type", inst_type, 0);
    chk("addi_rd", rd, 1);
    chk("addi_rs1", rs1, 0);
    chk("addi_imm", imm, 5);
    chk("addi_wen", r_wen, 1);
    chk("addi_pc", out_pc, 64'h8000_0000);
    drive(1, 32'hFE112E23, 64'h8000_0004);
    step();
    chk("sw_type", inst_type, 2);
    chk("sw_rs1", rs1, 2);
    chk("sw_rs2", rs2, 1);
    chk("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_wen", r_wen, 0);
    drive(1, 32'hFE000CE3, 64'h8000_0008);
    step();
    chk("beq_type", inst_type, 5);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(1, 32'h0000_0000, 64'h8000_000C);
    step();
    chk("ill_type", inst_type, 7);
    chk("ill_flag", illegal, 1);
    chk("ill_wen", r_wen, 0);
    chk("ill_cnt_1", ill_cnt, 1);
    drive(0, 0, 0);
    step();
    out_ready = 0;
    drive(1, 32'h00100093, 64'h100);
    step();
    drive(1, 32'h00200113, 64'h104);
    step();
    chk("abc_a_held", out_pc, 64'h100);
    chk("abc_skid_full", in_ready, 0);
    drive(1, 32'h00300193, 64'h108);
    step();
    chk("abc_a_held2", out_pc, 64'h100);
    chk("abc_c_blocked", in_ready, 0);
    step();
    chk("abc_a_held3", out_pc, 64'h100);
    out_ready = 1;
    step();
    chk("abc_b_out", out_pc, 64'h104);
    step();
    chk("abc_c_out", out_pc, 64'h108);
    drive(0, 0, 0);
    step();
    chk("abc_empty", out_valid, 0);
    out_ready = 0;
    drive(1, 32'h00400213, 64'h200);
    step();
    drive(1, 32'h00500293, 64'h204);
    step();
    chk("flush_pre_full", in_ready, 0);
    flush = 1;
    drive(1, 32'hFFFF_FFFF, 64'h208);
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt", ill_cnt, 1);
    flush = 0;
    drive(0, 0, 0);
    step();
    chk("flush_no_capture", out_valid, 0);
    drive(1, 32'h00600313, 64'h300);
    step();
    drive(1, 32'hFFFF_FFFF, 64'h304);
    step();
    drive(0, 0, 0);
    #2 rst = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", ill_cnt, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_imm", imm, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    drive(1, 32'h00700393, 64'h400);
    step();
    chk("post_arst_first", out_pc, 64'h400);
    drive(0, 0, 0);
    step();
    chk("post_arst_empty", out_valid, 0);
    repeat (4000) begin
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      r = $urandom;
      if ($urandom_range(0, 4) == 0) drive($urandom_range(0, 3) != 0, r, {$urandom, $urandom});
      else drive($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 11)]}, {$urandom, $urandom});
      step();
    end
    flush = 0;
    drive(0, 0, 0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64: immediate/PC width; legal values 32, 64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1: discard all held instructions.
REQ-006 SHALL have port in_valid  input  1: upstream holds an instruction.
REQ-007 SHALL have port in_ready  output  1: stage accepts an instruction this cycle.
REQ-008 SHALL have port instruction  input  32: raw RV instruction.
REQ-009 SHALL have port in_pc  input  XLEN: PC of that instruction.
REQ-010 SHALL have port out_valid  output  1: decoded bundle valid.
REQ-011 SHALL have port out_ready  input  1: downstream consumes the bundle.
REQ-012 SHALL have port out_pc  output  XLEN: PC of the bundle.
REQ-013 SHALL have port inst_type  output  3: I=0, U=1, S=2, J=3, R=4, B=5, ILL=7.
REQ-014 SHALL have ports rd, rs1, rs2  output  5 each: instruction[11:7], [19:15], [24:20].
REQ-015 SHALL have port imm  output  XLEN: sign-extended immediate (0 for R and ILL).
REQ-016 SHALL have port r_wen  output  1: instruction writes a register.
REQ-017 SHALL have port illegal  output  1: opcode not in the decode table.
REQ-018 SHALL have port ill_cnt  output  CNT_W: count of illegal instructions accepted.

Function
REQ-019 SHALL map opcodes as follows; any other opcode, or instruction[1:0] != 2'b11, decodes to ILL.
- TYPE_I: 0010011, 0011011, 0000011, 1100111, 1110011.
- TYPE_U: 0110111, 0010111.
- TYPE_S: 0100011.
- TYPE_J: 1101111.
- TYPE_R: 0110011, 0111011.
- TYPE_B: 1100011.
REQ-020 SHALL form immediates per the RV base ISA.
- I: inst[31:20]. S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}. J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- All sign-extended from the top instruction bit to XLEN.
REQ-021 SHALL drive r_wen=1 only for types I, U, J, R with rd != 0; r_wen=0 otherwise.
REQ-022 SHALL register all outputs: a bundle accepted at edge N appears at out_valid/outputs after edge N (latency 1 cycle).
REQ-023 SHALL accept an input when in_valid && in_ready; SHALL complete an output transfer when out_valid && out_ready.
REQ-024 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-025 SHALL contain an output register plus a one-entry skid register, sustaining 1 transfer/cycle with no combinational path from out_ready to in_ready.
REQ-026 SHALL drive in_ready = !skid_valid (registered).
REQ-027 SHALL route data as follows:
- Accepted while the output is empty or transferring: loads the output register.
- Accepted while the output is stalled: loads the skid register.
- When the output drains: the skid moves to the output on the same edge.
REQ-028 SHALL preserve program order; no bundle is duplicated or dropped except by flush.
REQ-029 SHALL, when flush=1 at an edge:
- clear out_valid and skid_valid;
- ignore in_valid that cycle (no capture, no ill_cnt increment).
Flush dominates simultaneous accept and transfer.
REQ-030 SHALL increment ill_cnt by 1 per accepted ILL instruction, saturating at 2^CNT_W-1; flush does not clear it.
REQ-031 SHALL decode instructions only; decoded fields carry no execution semantics beyond REQ-019..021.

Reset
REQ-032 SHALL, while rst=0, asynchronously force the following to 0: out_valid, skid_valid, ill_cnt, inst_type, rd, rs1, rs2, imm, out_pc, r_wen, illegal.
REQ-033 SHALL drive in_ready=1 from the first edge after rst deasserts.
REQ-034 SHALL discard any in-flight bundle on reset mid-operation, with nothing emitted afterwards from pre-reset state.

Verification
REQ-035 SHALL cover: 0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1 -> next cycle: out_valid=1, type=0, rd=1, rs1=0, imm=5, r_wen=1, out_pc=0x80000000.
REQ-036 SHALL cover: 0xFE112E23 (sw x1,-4(x2)), XLEN=64 -> type=2, rs1=2, rs2=1, imm=0xFFFFFFFFFFFFFFFC, r_wen=0.
REQ-037 SHALL cover: 0xFE000CE3 (beq x0,x0,-8) then 0x00000000 -> first bundle type=5, imm=-8; second bundle type=7, illegal=1, r_wen=0, ill_cnt=1.
REQ-038 SHALL cover: back-to-back inputs A, B, C with out_ready=0 for 3 cycles:
- A held at output, B in skid, in_ready=0, C held upstream;
- after out_ready=1: A, B, C emitted on consecutive cycles.
REQ-039 SHALL cover: stall with output and skid full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle input not captured, ill_cnt unchanged.
REQ-040 SHALL cover: rst pulled low mid-stream between edges -> outputs and ill_cnt read 0 immediately; after release, first emitted bundle is the first post-reset input.
